// File: rtl/ser_frame_pkg.sv
// ---------------------------------------------------------------------------
// ser_frame_pkg
// Shared types and constants for the serial frame controller slice.
//   state_t      : frame controller FSM states
//   ADDR_W_DEF   : default address field width (lanes = 2**ADDR_W)
//   LEN_W_DEF    : default length field width (max payload = 2**LEN_W-1)
//   FIELD_CNT_W  : width of the per-field bit counter in ser_field_shifter
// ---------------------------------------------------------------------------
package ser_frame_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int LEN_W_DEF  = 4;

  // Counter must hold values up to the widest field length.
  localparam int FIELD_CNT_W =
    $clog2(((ADDR_W_DEF > LEN_W_DEF) ? ADDR_W_DEF : LEN_W_DEF) + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    PARITY,
    DONE
  } state_t;

endpackage

// File: rtl/ser_field_shifter.sv
// ---------------------------------------------------------------------------
// ser_field_shifter
// N-bit MSB-first shift register with a bit counter, used to assemble one
// header field (address or length) of a serial frame.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart the field (counter cleared; data too if CLR_DATA)
//   shift_i       : shift bit_i in at the LSB end
//   bit_i         : serial input bit
//   data_o        : assembled field contents
//   full_o        : high when the current shift delivers the N-th bit
// Parameters:
//   N        : field width
//   CW       : bit counter width
//   CLR_DATA : 1 = clr_i also zeroes the data register
// ---------------------------------------------------------------------------
module ser_field_shifter #(
  parameter int N        = 2,
  parameter int CW       = 3,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         bit_i,
  output logic [N-1:0] data_o,
  output logic         full_o
);

  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Asserted combinationally so the FSM can leave the field state on the
  // same step that supplies the last bit.
  assign full_o = shift_i && (cnt_q == CW'(N - 1));
  assign data_o = data_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
      if (CLR_DATA) begin
        data_d = '0;
      end
    end else if (shift_i) begin
      // Truncating the concatenation drops the old MSB; works for any N >= 1.
      data_d = N'({data_q, bit_i});
      cnt_d  = full_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ser_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ser_frame_ctrl
// Sequences one serial frame: start bit (0), ADDR_W-bit address, LEN_W-bit
// length, LEN data bits. Data is steered to the addressed lane via a one-hot
// valid; the remaining-bit count feeds the 7-segment decoder.
// Ports:
//   clk_i        : system clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   clk_en_i     : one-cycle step pulse from the one-pulser
//   ser_in_i     : serial input bit, sampled when clk_en_i=1
//   ser_out_o    : combinational copy of ser_in_i for the lanes
//   out_valid_o  : one-hot lane valid, high throughout DATA
//   port_sel_o   : captured address
//   count_out_o  : remaining payload bits
//   busy_o       : high in every state except IDLE
//   done_o       : one-clock pulse at frame end
//   parity_err_o : even-parity error flag (SER_PARITY_EN builds only)
// Optional feature macro: SER_PARITY_EN adds a trailing even-parity bit.
// ---------------------------------------------------------------------------
module ser_frame_ctrl
  import ser_frame_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clk_en_i,
  input  logic                   ser_in_i,
  output logic                   ser_out_o,
  output logic [(2**ADDR_W)-1:0] out_valid_o,
  output logic [ADDR_W-1:0]      port_sel_o,
  output logic [LEN_W-1:0]       count_out_o,
  output logic                   busy_o,
  output logic                   done_o
`ifdef SER_PARITY_EN
  ,output logic                  parity_err_o
`endif
);

  localparam int NLANES = 2**ADDR_W;

  // State entered once the payload (possibly empty) is exhausted.
`ifdef SER_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NLANES-1:0]   valid_q, valid_d;

  logic                start_bit, addr_shift, addr_full, len_shift, len_full;
  logic [LEN_W-1:0]    len_field, len_next;

  assign start_bit  = (state_q == IDLE) && clk_en_i && !ser_in_i;
  assign addr_shift = (state_q == ADDR) && clk_en_i;
  assign len_shift  = (state_q == LEN)  && clk_en_i;
  // Value the length field will hold after this step; loaded into the counter
  // so the display tracks the partially assembled length.
  assign len_next   = LEN_W'({len_field, ser_in_i});

  // Address data is not cleared on a start bit: port_sel must keep the old
  // address until new address bits actually arrive.
  ser_field_shifter #(
    .N        (ADDR_W),
    .CW       (FIELD_CNT_W),
    .CLR_DATA (1'b0)
  ) u_addr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (start_bit),
    .shift_i (addr_shift),
    .bit_i   (ser_in_i),
    .data_o  (port_sel_o),
    .full_o  (addr_full)
  );

  ser_field_shifter #(
    .N        (LEN_W),
    .CW       (FIELD_CNT_W),
    .CLR_DATA (1'b1)
  ) u_len (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (start_bit),
    .shift_i (len_shift),
    .bit_i   (ser_in_i),
    .data_o  (len_field),
    .full_o  (len_full)
  );

  // DONE always lasts exactly one clock, regardless of clk_en.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE:   if (start_bit) state_d = ADDR;
      ADDR:   if (addr_full) state_d = LEN;
      LEN: begin
        if (len_shift) begin
          count_d = len_next;
          if (len_full) begin
            state_d = (len_next == '0) ? AFTER_DATA : DATA;
          end
        end
      end
      DATA: begin
        if (clk_en_i && (count_q != '0)) begin
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d = AFTER_DATA;
          end
        end
      end
      PARITY: if (clk_en_i) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    valid_d = (state_d == DATA) ? (NLANES'(1) << port_sel_o) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

`ifdef SER_PARITY_EN
  logic parity_acc_q, parity_acc_d;
  logic parity_err_q, parity_err_d;

  // Running XOR of the payload; the error is latched when the parity bit
  // arrives and survives until the next frame's start bit.
  always_comb begin
    parity_acc_d = parity_acc_q;
    parity_err_d = parity_err_q;
    if (start_bit) begin
      parity_acc_d = 1'b0;
      parity_err_d = 1'b0;
    end else if ((state_q == DATA) && clk_en_i) begin
      parity_acc_d = parity_acc_q ^ ser_in_i;
    end else if ((state_q == PARITY) && clk_en_i) begin
      parity_err_d = parity_acc_q ^ ser_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_acc_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_acc_q <= parity_acc_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err_o = parity_err_q;
`endif

  assign ser_out_o   = ser_in_i;
  assign count_out_o = count_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_ser_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ser_frame_ctrl
// Directed bench for ser_frame_ctrl with hand-computed expectations.
// Honours SER_PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_ser_frame_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       clkEn = 1'b0;
  logic       serIn = 1'b1;
  logic       serOut;
  logic [3:0] outValid;
  logic [1:0] portSel;
  logic [3:0] countOut;
  logic       busy;
  logic       done;
`ifdef SER_PARITY_EN
  logic       parityErr;
`endif

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  int lane3Cycles = 0;
  int anyValidCycles = 0;
  int d0, v0, l0;

  ser_frame_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .clk_en_i     (clkEn),
    .ser_in_i     (serIn),
    .ser_out_o    (serOut),
    .out_valid_o  (outValid),
    .port_sel_o   (portSel),
    .count_out_o  (countOut),
    .busy_o       (busy),
`ifdef SER_PARITY_EN
    .parity_err_o (parityErr),
`endif
    .done_o       (done)
  );

  // 10 ns clock period
  always #5 clk = ~clk;

  // Cycle monitors sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (done) doneCount++;
    if (outValid == 4'b1000) lane3Cycles++;
    if (outValid != 4'b0000) anyValidCycles++;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk_en step carrying bit b; returns just after the following negedge
  task automatic applyStimulus(input logic b);
    @(negedge clk);
    clkEn = 1'b1;
    serIn = b;
    @(negedge clk);
    #1;
    clkEn = 1'b0;
  endtask

  // Sends the n low bits of 'bits' MSB first, one step each
  task automatic sendBits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(bits[i]);
  endtask

  // Back-to-back stepping: clk_en stays high, a new bit every negedge
  task automatic holdBit(input logic b);
    @(negedge clk);
    clkEn = 1'b1;
    serIn = b;
  endtask

  // Hard time limit so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_portsel", portSel, 0);
    checkOutput("rst_count", countOut, 0);
`ifdef SER_PARITY_EN
    checkOutput("rst_perr", parityErr, 0);
`endif
    rstN = 1'b1;
    @(negedge clk);

    // Idle bits (1) never start a frame
    repeat (3) applyStimulus(1'b1);
    checkOutput("idle_busy", busy, 0);

    // ser_out follows ser_in combinationally
    serIn = 1'b0; #1;
    checkOutput("serout0", serOut, 0);
    serIn = 1'b1; #1;
    checkOutput("serout1", serOut, 1);

    // Frame 0|10|0011|1,0,1
    d0 = doneCount;
    applyStimulus(1'b0);
    checkOutput("f2_busy", busy, 1);
    sendBits(16'b10, 2);
    checkOutput("f2_portsel", portSel, 2);
    sendBits(16'b0011, 4);
    checkOutput("f2_count3", countOut, 3);
    checkOutput("f2_valid_a", outValid, 4'b0100);
    applyStimulus(1'b1);
    checkOutput("f2_count2", countOut, 2);
    checkOutput("f2_valid_b", outValid, 4'b0100);
    applyStimulus(1'b0);
    checkOutput("f2_count1", countOut, 1);
    checkOutput("f2_valid_c", outValid, 4'b0100);
    applyStimulus(1'b1);
    checkOutput("f2_count0", countOut, 0);
`ifdef SER_PARITY_EN
    applyStimulus(1'b0);
`endif
    checkOutput("f2_done", done, 1);
    checkOutput("f2_valid_off", outValid, 0);
    @(negedge clk); #1;
    checkOutput("f2_done_drop", done, 0);
    checkOutput("f2_idle_busy", busy, 0);
    checkOutput("f2_count_hold", countOut, 0);
    checkOutput("f2_portsel_hold", portSel, 2);
    checkOutput("f2_done_pulses", doneCount - d0, 1);

    // Zero-length frame 0|01|0000
    d0 = doneCount;
    v0 = anyValidCycles;
    applyStimulus(1'b0);
    sendBits(16'b01, 2);
    sendBits(16'b0000, 4);
`ifdef SER_PARITY_EN
    applyStimulus(1'b0);
`endif
    checkOutput("f3_done", done, 1);
    checkOutput("f3_count", countOut, 0);
    checkOutput("f3_portsel", portSel, 1);
    @(negedge clk); #1;
    checkOutput("f3_no_valid", anyValidCycles - v0, 0);
    checkOutput("f3_done_pulses", doneCount - d0, 1);
    checkOutput("f3_busy", busy, 0);

    // Max-length frame on port 3, clk_en held high throughout
    d0 = doneCount;
    l0 = lane3Cycles;
    holdBit(1'b0);
    repeat (2) holdBit(1'b1);
    repeat (4) holdBit(1'b1);
    repeat (15) holdBit(1'b1);
`ifdef SER_PARITY_EN
    holdBit(1'b1);
`endif
    repeat (4) holdBit(1'b1);
    @(negedge clk); #1;
    clkEn = 1'b0;
    checkOutput("f4_data_cycles", lane3Cycles - l0, 15);
    checkOutput("f4_done_pulses", doneCount - d0, 1);
    checkOutput("f4_count", countOut, 0);
    checkOutput("f4_busy", busy, 0);
    checkOutput("f4_portsel", portSel, 3);

    // Stall 20 cycles in the middle of the length field
    d0 = doneCount;
    applyStimulus(1'b0);
    sendBits(16'b00, 2);
    sendBits(16'b10, 2);
    checkOutput("f5_partial", countOut, 2);
    repeat (20) @(negedge clk);
    checkOutput("f5_frozen", countOut, 2);
    checkOutput("f5_busy", busy, 1);
    checkOutput("f5_valid", outValid, 0);
    sendBits(16'b01, 2);
    checkOutput("f5_len", countOut, 9);
    checkOutput("f5_lane0", outValid, 4'b0001);
    repeat (8) applyStimulus(1'b1);
    checkOutput("f5_count1", countOut, 1);
    applyStimulus(1'b1);
    checkOutput("f5_count0", countOut, 0);
`ifdef SER_PARITY_EN
    applyStimulus(1'b1);
`endif
    checkOutput("f5_done", done, 1);
    @(negedge clk); #1;
    checkOutput("f5_done_pulses", doneCount - d0, 1);

`ifdef SER_PARITY_EN
    // Data 1,1,0 with parity 1 -> error; error clears on next start bit
    applyStimulus(1'b0);
    sendBits(16'b00, 2);
    sendBits(16'b0011, 4);
    sendBits(16'b110, 3);
    applyStimulus(1'b1);
    checkOutput("p_err_set", parityErr, 1);
    checkOutput("p_done", done, 1);
    @(negedge clk); #1;
    checkOutput("p_err_held", parityErr, 1);
    applyStimulus(1'b0);
    checkOutput("p_err_clear", parityErr, 0);
    sendBits(16'b00, 2);
    sendBits(16'b0011, 4);
    sendBits(16'b110, 3);
    applyStimulus(1'b0);
    checkOutput("p_err_ok", parityErr, 0);
    @(negedge clk); #1;
    // Zero-length frame with parity 1 is an error
    applyStimulus(1'b0);
    sendBits(16'b00, 2);
    sendBits(16'b0000, 4);
    applyStimulus(1'b1);
    checkOutput("p_zero_err", parityErr, 1);
    @(negedge clk); #1;
`endif

    // Reset asserted mid-DATA aborts immediately with no done pulse
    applyStimulus(1'b0);
    sendBits(16'b11, 2);
    sendBits(16'b0101, 4);
    applyStimulus(1'b1);
    checkOutput("r_count4", countOut, 4);
    checkOutput("r_valid", outValid, 4'b1000);
    d0 = doneCount;
    @(negedge clk); #2;
    rstN = 1'b0;
    #1;
    checkOutput("r_busy", busy, 0);
    checkOutput("r_valid0", outValid, 0);
    checkOutput("r_count0", countOut, 0);
    checkOutput("r_portsel0", portSel, 0);
    checkOutput("r_done0", done, 0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    repeat (2) applyStimulus(1'b1);
    checkOutput("r_idle_busy", busy, 0);
    checkOutput("r_no_done", doneCount - d0, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
